// File: rtl/bitmap_load_ctrl.sv
// bitmap_load_ctrl: sequences every write into the font bitmap RAM write port.
// Two CPU commands are handled: LOAD streams one 16-row glyph in byte by byte,
// FILL paints a run of glyphs with a constant byte. At most one RAM write per cycle.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only while idle)
//   cmd_op_i                 0 = LOAD, 1 = FILL
//   cmd_char_i               first character index
//   cmd_count_i              FILL glyph count (1..128)
//   cmd_fill_i               FILL byte
//   data_valid_i/data_ready_o/data_byte_i  LOAD row data, row 0 first
//   abort_i                  abort an active LOAD/FILL (ignored when idle)
//   write_data_o/write_addr_o/write_strobe_o  bitmap RAM write port, addr = {char, row}
//   busy_o, done_o, err_o    status: active, success pulse, failure pulse
module bitmap_load_ctrl #(
  parameter int unsigned LoadTimeout = 1023,
  parameter int unsigned Rows        = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_op_i,
  input  logic [6:0]  cmd_char_i,
  input  logic [7:0]  cmd_count_i,
  input  logic [7:0]  cmd_fill_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  input  logic [7:0]  data_byte_i,
  input  logic        abort_i,
  output logic [7:0]  write_data_o,
  output logic [10:0] write_addr_o,
  output logic        write_strobe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned ToW     = (LoadTimeout < 2) ? 1 : $clog2(LoadTimeout + 1);
  localparam logic [3:0]  LastRow = 4'(Rows - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFill} state_e;

  state_e           state_q;
  logic [6:0]       char_q;
  logic [3:0]       row_q;
  logic [7:0]       remain_q;
  logic [7:0]       fill_q;
  logic [ToW-1:0]   to_q;
  logic             strobe_q;
  logic [10:0]      addr_q;
  logic [7:0]       data_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             cmd_ready_q;
  logic             data_ready_q;

  // 9-bit sum so char + count past the last glyph is caught without wrapping.
  logic [8:0] fill_end;
  logic       fill_bad;
  logic       load_timeout;

  assign fill_end     = {2'b00, cmd_char_i} + {1'b0, cmd_count_i};
  assign fill_bad     = (cmd_count_i == 8'd0) || (fill_end > 9'd128);
  assign load_timeout = (LoadTimeout != 0) && ((32'(to_q) + 32'd1) == LoadTimeout);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      char_q       <= '0;
      row_q        <= '0;
      remain_q     <= '0;
      fill_q       <= '0;
      to_q         <= '0;
      strobe_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort is deliberately not looked at here.
          if (cmd_valid_i) begin
            if (!cmd_op_i) begin
              char_q       <= cmd_char_i;
              row_q        <= '0;
              to_q         <= '0;
              state_q      <= StLoad;
              busy_q       <= 1'b1;
              cmd_ready_q  <= 1'b0;
              data_ready_q <= 1'b1;
            end else if (fill_bad) begin
              err_q <= 1'b1;
            end else begin
              char_q      <= cmd_char_i;
              row_q       <= '0;
              remain_q    <= cmd_count_i;
              fill_q      <= cmd_fill_i;
              state_q     <= StFill;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
            end
          end
        end
        StLoad: begin
          if (abort_i) begin
            err_q        <= 1'b1;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            data_ready_q <= 1'b0;
          end else if (data_valid_i) begin
            strobe_q <= 1'b1;
            addr_q   <= {char_q, row_q};
            data_q   <= data_byte_i;
            row_q    <= row_q + 4'd1;
            to_q     <= '0;
            if (row_q == LastRow) begin
              done_q       <= 1'b1;
              state_q      <= StIdle;
              busy_q       <= 1'b0;
              cmd_ready_q  <= 1'b1;
              data_ready_q <= 1'b0;
            end
          end else if (load_timeout) begin
            err_q        <= 1'b1;
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            data_ready_q <= 1'b0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StFill: begin
          if (abort_i) begin
            err_q       <= 1'b1;
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end else begin
            strobe_q <= 1'b1;
            addr_q   <= {char_q, row_q};
            data_q   <= fill_q;
            row_q    <= row_q + 4'd1;
            if (row_q == LastRow) begin
              if (remain_q == 8'd1) begin
                done_q      <= 1'b1;
                state_q     <= StIdle;
                busy_q      <= 1'b0;
                cmd_ready_q <= 1'b1;
              end else begin
                // Range check at accept time keeps char_q from passing 127.
                char_q   <= char_q + 7'd1;
                remain_q <= remain_q - 8'd1;
              end
            end
          end
        end
        default: begin
          state_q      <= StIdle;
          busy_q       <= 1'b0;
          cmd_ready_q  <= 1'b1;
          data_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign data_ready_o   = data_ready_q;
  assign write_strobe_o = strobe_q;
  assign write_addr_o   = addr_q;
  assign write_data_o   = data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
